// File: rtl/fma16_sched.sv
// Round-robin scheduler and sequencer for a shared fma16 datapath.
// Two requesters are arbitrated, the opcode is decoded, operands are held for LATENCY cycles, then the result is returned.
module fma16_sched #(
  parameter int unsigned LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [2:0]  req0_op,
  input  logic [15:0] req0_x,
  input  logic [15:0] req0_y,
  input  logic [15:0] req0_z,
  input  logic [1:0]  req0_rm,

  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [2:0]  req1_op,
  input  logic [15:0] req1_x,
  input  logic [15:0] req1_y,
  input  logic [15:0] req1_z,
  input  logic [1:0]  req1_rm,

  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [15:0] rsp_result,
  output logic        rsp_err,

  output logic [15:0] fma_x,
  output logic [15:0] fma_y,
  output logic [15:0] fma_z,
  output logic        fma_mul,
  output logic        fma_add,
  output logic        fma_negr,
  output logic        fma_negz,
  output logic [1:0]  fma_roundmode,
  input  logic [15:0] fma_result,

  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] COUNT_LOAD = 4'(LATENCY - 1);
  localparam logic [15:0] QNAN = 16'h7E00;

  state_t      state;
  logic [3:0]  count;
  logic        last_grant;

  logic        grant;
  logic        accept;
  logic [2:0]  sel_op;
  logic [15:0] sel_x;
  logic [15:0] sel_y;
  logic [15:0] sel_z;
  logic [1:0]  sel_rm;
  logic        legal;
  logic [3:0]  ctrl;

  // Winner: the lone valid requester, or the one not granted last on a tie.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) grant = ~last_grant;
    else if (req1_valid)          grant = 1'b1;
  end

  assign req0_ready = (state == IDLE) && req0_valid && !grant;
  assign req1_ready = (state == IDLE) && req1_valid &&  grant;
  assign accept     = req0_ready || req1_ready;

  assign sel_op = grant ? req1_op : req0_op;
  assign sel_x  = grant ? req1_x  : req0_x;
  assign sel_y  = grant ? req1_y  : req0_y;
  assign sel_z  = grant ? req1_z  : req0_z;
  assign sel_rm = grant ? req1_rm : req0_rm;

  // ctrl is {mul, add, negr, negz}.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs; otherwise a latch is inferred.
    legal = 1'b1;
    ctrl  = 4'b0000;
    unique case (sel_op)
      3'b000: ctrl = 4'b0100;
      3'b001: ctrl = 4'b0101;
      3'b010: ctrl = 4'b1000;
      3'b011: ctrl = 4'b1100;
      3'b100: ctrl = 4'b1101;
      3'b101: ctrl = 4'b1110;
      3'b110: ctrl = 4'b1111;
      3'b111: legal = 1'b0;
    endcase
  end

  // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      count         <= '0;
      last_grant    <= 1'b1;
      busy          <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_id        <= 1'b0;
      rsp_result    <= '0;
      rsp_err       <= 1'b0;
      fma_x         <= '0;
      fma_y         <= '0;
      fma_z         <= '0;
      fma_mul       <= 1'b0;
      fma_add       <= 1'b0;
      fma_negr      <= 1'b0;
      fma_negz      <= 1'b0;
      fma_roundmode <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            last_grant <= grant;
            rsp_id     <= grant;
            busy       <= 1'b1;
            if (legal) begin
              fma_x         <= sel_x;
              fma_y         <= sel_y;
              fma_z         <= sel_z;
              fma_roundmode <= sel_rm;
              {fma_mul, fma_add, fma_negr, fma_negz} <= ctrl;
              count         <= COUNT_LOAD;
              state         <= EXEC;
            end else begin
              // Illegal op skips the datapath and answers with a quiet NaN.
              rsp_result <= QNAN;
              rsp_err    <= 1'b1;
              rsp_valid  <= 1'b1;
              state      <= RESP;
            end
          end
        end
        EXEC: begin
          if (count == 4'd0) begin
            rsp_result <= fma_result;
            rsp_err    <= 1'b0;
            rsp_valid  <= 1'b1;
            state      <= RESP;
          end else begin
            count <= count - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
